// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive framing engine.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_frame_tick_cnt.sv
// Oversample counter for one bit period: clears or advances only on baud ticks,
// and flags the mid-bit and last-tick positions.
module uart_rx_tick_cnt
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clr,
    output logic mid,
    output logic last
);
    localparam int CW = $clog2(OVERSAMPLE);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = clr ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid  = (cnt_q == CW'(mid_tick(OVERSAMPLE)));
    assign last = (cnt_q == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framing: start validation, LSB-first data shift, stop check.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 strt_bit,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int BW = $clog2(DATA_BITS);

    rx_state_e            state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 cnt_clr, tick_mid, tick_last;
    logic                 parity_ok;

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
    logic par_bit_q, par_bit_d;
    logic parity_err_q, parity_err_d;
    assign parity_ok  = ~^{shift_q, par_bit_q};
    assign parity_err = parity_err_q;
`else
    localparam rx_state_e AFTER_DATA = STOP;
    assign parity_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    uart_rx_tick_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_tick_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (baud_tick),
        .clr   (cnt_clr),
        .mid   (tick_mid),
        .last  (tick_last)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        cnt_clr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (strt_bit) state_d = START;
                end
                START: begin
                    if (tick_mid) begin
                        cnt_clr = 1'b1;
                        if (strt_bit) begin
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        cnt_clr   = 1'b1;
                        shift_d   = {rx_in, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_last) begin
                        cnt_clr   = 1'b1;
                        par_bit_d = rx_in;
                        state_d   = STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_last) begin
                        cnt_clr = 1'b1;
                        if (rx_in) begin
                            state_d = IDLE;
                            if (parity_ok) begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            if (!parity_ok) parity_err_d = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end
                end
                // Line held low after a bad stop: wait for it to recover before re-arming.
                WAIT_HIGH: begin
                    cnt_clr = 1'b1;
                    if (rx_in) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Receive-side framing engine for the UART. Sits directly downstream of the start-bit detector and consumes its `strt_bit` (high while the line is low) together with the synchronized serial line.
- Oversamples each bit period with a 16x baud tick and validates the start bit at mid-bit.
- Shifts in data bits LSB-first at mid-bit, checks the stop bit, then presents a parallel byte with a one-cycle valid pulse, or flags a framing error.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, baud ticks per bit period (even, >= 8).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- strt_bit  input  1  start-bit indication from the detector (1 = line low).
- rx_in  input  1  synchronized serial line, idle high.
- rx_data  output  DATA_BITS  last correctly received word.
- rx_valid  output  1  one-clk pulse: rx_data updated.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- parity_err  output  1  one-clk pulse: parity mismatch (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock domain. Reset is synchronous, active-low. On reset: state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0.
- Reset mid-frame aborts the frame. No pulse is emitted and rx_data is not updated.
- tick_cnt and bit_cnt advance only on clk edges where baud_tick=1. Sampling happens only on such edges. MID = OVERSAMPLE/2-1; LAST = OVERSAMPLE-1.
- IDLE: on baud_tick with strt_bit=1, set tick_cnt=0 and go to START.
- START: on each tick, tick_cnt++. When tick_cnt==MID on a tick:
  - if strt_bit=1, set tick_cnt=0, bit_cnt=0, go to DATA;
  - otherwise this is a false start: go to IDLE with no outputs.
- DATA: when tick_cnt==LAST on a tick:
  - shift = {rx_in, shift[DATA_BITS-1:1]} (LSB first), tick_cnt=0, bit_cnt++;
  - after DATA_BITS samples, go to STOP (or PARITY when enabled).
- STOP: when tick_cnt==LAST on a tick, sample rx_in:
  - rx_in=1: rx_data<=shift and rx_valid=1 for exactly the next clk cycle, then go to IDLE;
  - rx_in=0: frame_err=1 for one cycle, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH (break/line-stuck recovery): stay until a tick with rx_in=1, then go to IDLE. New starts are ignored here.
- Output pulses are registered: they appear in the clk cycle after the sampling tick edge. rx_valid, frame_err and parity_err are never asserted in the same cycle.
- rx_data holds its value until the next good frame.
- A start detected on the first tick after returning to IDLE is accepted, so back-to-back frames need no extra gap.
- baud_tick asserted on consecutive clks is legal. Each tick counts.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - a PARITY state follows DATA and samples one extra bit at tick_cnt==LAST;
  - even parity: XOR of data bits and parity bit must be 0;
  - in STOP, a good stop bit with a parity mismatch gives a parity_err pulse instead of rx_valid, and rx_data is not updated;
  - a bad stop bit gives frame_err regardless of parity.
- Undefined: no PARITY state, the frame is start + DATA_BITS + stop, and parity_err is tied 0.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - default OVERSAMPLE and DATA_BITS constants;
  - function returning MID for a given OVERSAMPLE.
- One natural sub-module, uart_rx_tick_cnt: oversample counter with clear, advance-on-tick and mid/last strobes.

Test Plan:
- Send 0xA5 (8N1, 16 ticks/bit) -> single rx_valid pulse one clk after the stop-bit mid-sample tick, rx_data=0xA5, frame_err=0, busy low afterwards.
- Line low for 3 ticks, then high -> START aborts at the tick_cnt==MID check (the 8th tick), returns to IDLE, no pulses, rx_data unchanged.
- Send 0x3C with stop bit forced 0, line held low 40 ticks, then high -> frame_err pulse, rx_data holds its previous value, no restart until a high tick in WAIT_HIGH, next frame 0x5A received correctly.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two rx_valid pulses, 160 ticks apart, data correct.
- Assert rst_n=0 mid-DATA (after 4 bits of 0x81) -> all outputs 0 next cycle, then next full frame 0x81 received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> rx_valid, rx_data=0x07; same byte with parity bit 0 -> parity_err pulse, rx_data unchanged.
